// File: rtl/binary_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package binary_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of a counter that must hold the values 0..width inclusive.
    function automatic int unsigned calc_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/binary_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
module binary_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift, compare and conditionally restore.
    // rem_i[WIDTH] is always 0 in normal operation; OR-ing it in keeps the
    // compare correct even if the top bit were ever set.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = rem_i[WIDTH] | (shifted >= {1'b0, divisor_i});
        rem_o   = q_o ? diff : shifted;
    end

endmodule

// File: rtl/binary_divider_seq.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per clock; divide-by-zero reported via div_by_zero.
// Optional macro SIGNED_DIV_EN: two's complement operands, sign-corrected
// results (quotient truncates toward zero, remainder follows dividend sign).
module binary_divider_seq
    import binary_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = int'(calc_cnt_w(WIDTH));

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
`endif

    binary_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (shreg_q[WIDTH-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    // Operand magnitudes on accept and sign-corrected final results.
    always_comb begin
`ifdef SIGNED_DIV_EN
        mag_a = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        mag_b = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
        q_fin = {shreg_q[WIDTH-2:0], step_q};
        r_fin = step_rem[WIDTH-1:0];
        if (qneg_q) q_fin = ~q_fin + 1'b1;
        if (rneg_q) r_fin = ~r_fin + 1'b1;
`else
        mag_a = dividend;
        mag_b = divisor;
        q_fin = {shreg_q[WIDTH-2:0], step_q};
        r_fin = step_rem[WIDTH-1:0];
`endif
    end

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dbz_d     = dbz_q;
`ifdef SIGNED_DIV_EN
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            CALC: begin
                cnt_d   = cnt_q - CNT_W'(1);
                rem_d   = step_rem;
                shreg_d = {shreg_q[WIDTH-2:0], step_q};
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    quot_d  = q_fin;
                    remd_d  = r_fin;
                end
            end
            default: begin
                // IDLE and DONE share the accept path; DONE falls back to IDLE.
                state_d = IDLE;
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remd_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d   = CALC;
                        cnt_d     = CNT_W'(WIDTH);
                        rem_d     = '0;
                        shreg_d   = mag_a;
                        divisor_d = mag_b;
`ifdef SIGNED_DIV_EN
                        qneg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d    = dividend[WIDTH-1];
`endif
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            remd_q    <= '0;
            dbz_q     <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            remd_q    <= remd_d;
            dbz_q     <= dbz_d;
`ifdef SIGNED_DIV_EN
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_binary_divider_seq.sv
// Directed self-checking bench for binary_divider_seq (WIDTH=8 and WIDTH=4).
module tb_binary_divider_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] q8, r8;

    logic       start4 = 1'b0;
    logic [3:0] dvd4 = '0, dvs4 = '0;
    logic       busy4, done4, dbz4;
    logic [3:0] q4, r4;

    int tests = 0;
    int fails = 0;
    int n;
    int pulses;
    logic [7:0] exp_q, exp_r;

    always #5 clk = ~clk;

    binary_divider_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    binary_divider_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one accepting edge; returns #1 after it.
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Advance until done8; n counts edges from the accepting edge (=1).
    task automatic wait8(input int n0, output int nout);
        nout = n0;
        while (!done8 && nout < 40) begin
            @(posedge clk); #1;
            nout++;
        end
    endtask

    task automatic wait4(input int n0, output int nout);
        nout = n0;
        while (!done4 && nout < 40) begin
            @(posedge clk); #1;
            nout++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_flags", {29'd0, busy8, done8, dbz8}, 32'd0);
        chk("rst8_qr", {16'd0, q8, r8}, 32'd0);
        chk("rst4_all", {21'd0, busy4, done4, dbz4, q4, r4}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // WIDTH=4: 10/10 (signed view -6/-6 gives the same result)
        start4 = 1'b1; dvd4 = 4'd10; dvs4 = 4'd10;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("w4_busy", {31'd0, busy4}, 32'd1);
        wait4(1, n);
        chk("w4_lat", n, 32'd5);
        chk("w4_res", {23'd0, dbz4, q4, r4}, {23'd0, 1'b0, 4'd1, 4'd0});

        // WIDTH=8: 200/7 with an ignored start during CALC
`ifdef SIGNED_DIV_EN
        exp_q = 8'hF8; exp_r = 8'h00;   // -56/7
`else
        exp_q = 8'd28; exp_r = 8'd4;
`endif
        go8(8'd200, 8'd7);
        chk("d200_busy", {31'd0, busy8}, 32'd1);
        @(posedge clk); #1;
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8(3, n);
        chk("d200_lat", n, 32'd9);
        chk("d200_res", {15'd0, dbz8, q8, r8}, {15'd0, 1'b0, exp_q, exp_r});
        @(posedge clk); #1;
        chk("d200_hold", {14'd0, done8, busy8, q8, r8}, {16'd0, exp_q, exp_r});

        // Divide by zero: 37/0
        go8(8'd37, 8'd0);
        chk("dz_done", {30'd0, done8, busy8}, 32'd2);
        chk("dz_res", {15'd0, dbz8, q8, r8}, {15'd0, 1'b1, 8'hFF, 8'd37});
        @(posedge clk); #1;
        chk("dz_after", {13'd0, done8, busy8, dbz8, q8, r8}, {13'd0, 3'b001, 8'hFF, 8'd37});

        // Edge results: dividend<divisor, dividend=0, divisor=1
        go8(8'd3, 8'd9);
        wait8(1, n);
        chk("lt_res", {15'd0, dbz8, q8, r8}, {15'd0, 1'b0, 8'd0, 8'd3});
        go8(8'd0, 8'd5);
        wait8(1, n);
        chk("zero_res", {16'd0, q8, r8}, 32'd0);
        go8(8'd173, 8'd1);
        wait8(1, n);
        chk("one_res", {16'd0, q8, r8}, {16'd0, 8'd173, 8'd0});

        // Reset mid-operation
        go8(8'd100, 8'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst", {13'd0, busy8, done8, dbz8, q8, r8}, 32'd0);
        rst = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        chk("mid_rst_nodone", pulses, 32'd0);
        go8(8'd100, 8'd3);
        wait8(1, n);
        chk("d100_lat", n, 32'd9);
        chk("d100_res", {16'd0, q8, r8}, {16'd0, 8'd33, 8'd1});

        // Back-to-back: start held through DONE of 255/16
`ifdef SIGNED_DIV_EN
        exp_q = 8'h00; exp_r = 8'hFF;   // -1/16
`else
        exp_q = 8'd15; exp_r = 8'd15;
`endif
        start8 = 1'b1; dvd8 = 8'd255; dvs8 = 8'd16;
        @(posedge clk); #1;
        dvd8 = 8'd9; dvs8 = 8'd2;
        wait8(1, n);
        chk("b2b_lat1", n, 32'd9);
        chk("b2b_res1", {16'd0, q8, r8}, {16'd0, exp_q, exp_r});
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b_accept", {31'd0, busy8}, 32'd1);
        wait8(1, n);
        chk("b2b_lat2", n, 32'd9);
        chk("b2b_res2", {16'd0, q8, r8}, {16'd0, 8'd4, 8'd1});

`ifdef SIGNED_DIV_EN
        go8(8'hF9, 8'd2);
        wait8(1, n);
        chk("s_m7_2", {15'd0, dbz8, q8, r8}, {15'd0, 1'b0, 8'hFD, 8'hFF});
        go8(8'h80, 8'hFF);
        wait8(1, n);
        chk("s_ovf", {15'd0, dbz8, q8, r8}, {15'd0, 1'b0, 8'h80, 8'h00});
        go8(8'hFB, 8'h00);
        chk("s_dz", {15'd0, dbz8, q8, r8}, {15'd0, 1'b1, 8'hFF, 8'hFB});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
